// File: rtl/skid_buf_pkg.sv
// Shared types and constants for the ready-registering skid buffer.
// The SKID_BUF_STATS_EN build option adds statistics counters; their width is set here.
package skid_buf_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int STAT_W         = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  // Occupancy reported on level; the state encoding is never exposed directly.
  function automatic logic [1:0] level_of(skid_state_t s);
    case (s)
      EMPTY:   return 2'd0;
      BUSY:    return 2'd1;
      FULL:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/skid_buf_if.sv
// Valid/ready bundle around the skid buffer: upstream, downstream, occupancy.
// The statistics members exist only when SKID_BUF_STATS_EN is defined.
interface skid_buf_if
  import skid_buf_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [1:0]        level;
`ifdef SKID_BUF_STATS_EN
  logic [STAT_W-1:0] in_count;
  logic [STAT_W-1:0] out_count;
  logic [STAT_W-1:0] stall_count;
`endif

  // slave: the buffer itself; master: the surrounding producer/consumer.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, level
`ifdef SKID_BUF_STATS_EN
    , output in_count, out_count, stall_count
`endif
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, level
`ifdef SKID_BUF_STATS_EN
    , input in_count, out_count, stall_count
`endif
  );

endinterface

// File: rtl/skid_buf_stat_cnt.sv
// Single wrapping event counter with enable and synchronous reset.
module skid_buf_stat_cnt
  import skid_buf_pkg::*;
#(
  parameter int W = STAT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/skid_buffer.sv
// Two-entry valid/ready slice with in_ready and out_valid driven from flops.
// Define SKID_BUF_STATS_EN to add in/out/stall counters on the interface.
//
// state | meaning
// EMPTY | no beat held, out_valid=0, in_ready=1
// BUSY  | main entry holds the head beat
// FULL  | main and skid both hold beats, in_ready=0
module skid_buffer
  import skid_buf_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic      clk,
  input  logic      rst,
  skid_buf_if.slave bus
);

  skid_state_t       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [1:0]        level_q;
  logic              in_fire;
  logic              out_fire;

  assign in_fire  = bus.in_valid & in_ready_q;
  assign out_fire = out_valid_q & bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_d  = bus.in_data;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_d = bus.in_data;
        end else if (in_fire) begin
          skid_d  = bus.in_data;
          state_d = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only the drain side can move.
        if (out_fire) begin
          main_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Handshake flags are re-derived from the next state so they stay flop outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      level_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
      level_q     <= level_of(state_d);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_q;
  assign bus.level     = level_q;

`ifdef SKID_BUF_STATS_EN
  logic              stall;
  logic [STAT_W-1:0] in_count_w;
  logic [STAT_W-1:0] out_count_w;
  logic [STAT_W-1:0] stall_count_w;

  assign stall = out_valid_q & ~bus.out_ready;

  skid_buf_stat_cnt #(.W(STAT_W)) u_in_cnt (
    .clk     (clk),
    .rst     (rst),
    .en_i    (in_fire),
    .count_o (in_count_w)
  );

  skid_buf_stat_cnt #(.W(STAT_W)) u_out_cnt (
    .clk     (clk),
    .rst     (rst),
    .en_i    (out_fire),
    .count_o (out_count_w)
  );

  skid_buf_stat_cnt #(.W(STAT_W)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .en_i    (stall),
    .count_o (stall_count_w)
  );

  assign bus.in_count    = in_count_w;
  assign bus.out_count   = out_count_w;
  assign bus.stall_count = stall_count_w;
`endif

endmodule

// File: tb/tb_skid_buffer.sv
// Scoreboard bench for skid_buffer: directed scenarios plus randomized handshake traffic,
// checked against an occupancy-level model of a depth-2 FIFO with registered flags.
module tb_skid_buffer;
  import skid_buf_pkg::*;

  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  skid_buf_if #(.DATA_W(DW)) bus();

  skid_buffer #(.DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] sb[$];
  bit            chk_en = 1'b0;

  int            occ = 0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [31:0]   m_in_cnt = '0;
  logic [31:0]   m_out_cnt = '0;
  logic [31:0]   m_stall_cnt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a 2-deep FIFO whose ready/valid reflect the occupancy before each edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("level", {30'd0, bus.level}, occ);
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, occ != 2});
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, occ != 0});
      if (prev_stall && occ != 0) chk("stall_hold", bus.out_data, prev_data);
`ifdef SKID_BUF_STATS_EN
      chk("in_count", bus.in_count, m_in_cnt);
      chk("out_count", bus.out_count, m_out_cnt);
      chk("stall_count", bus.stall_count, m_stall_cnt);
`endif
      if (rst) begin
        occ         = 0;
        prev_stall  = 1'b0;
        m_in_cnt    = '0;
        m_out_cnt   = '0;
        m_stall_cnt = '0;
      end else begin
        bit fi, fo;
        fi = bus.in_valid && (occ < 2);
        fo = bus.out_ready && (occ > 0);
        prev_stall = (occ > 0) && !bus.out_ready;
        prev_data  = bus.out_data;
        if (fi) m_in_cnt = m_in_cnt + 32'd1;
        if (fo) m_out_cnt = m_out_cnt + 32'd1;
        if (prev_stall) m_stall_cnt = m_stall_cnt + 32'd1;
        occ = occ + (fi ? 1 : 0) - (fo ? 1 : 0);
      end
    end
  end

  // Input side: every accepted beat becomes an expected output.
  always @(negedge clk) begin
    if (chk_en) begin
      if (rst) sb.delete();
      else if (bus.in_valid && bus.in_ready) sb.push_back(bus.in_data);
    end
  end

  // Output side: every delivered beat must be the oldest outstanding one.
  always @(negedge clk) begin
    if (chk_en && !rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_extra_beat: got %0h want none at %0t", bus.out_data, $time);
      end else begin
        logic [DW-1:0] exp;
        exp = sb.pop_front();
        chk("out_data", bus.out_data, exp);
      end
    end
  end

  task automatic cyc(input logic r, input logic v, input logic [DW-1:0] d, input logic o);
    rst           = r;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = o;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h11;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    // Reset holds off a valid beat, then the first beat after release goes through.
    cyc(1, 1, 32'h11, 1);
    cyc(1, 1, 32'h11, 1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_level", {30'd0, bus.level}, 32'd0);
    cyc(0, 1, 32'h11, 1);
    chk("first_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("first_data", bus.out_data, 32'h11);
    cyc(0, 0, 32'h0, 1);

    // Back-to-back streaming.
    cyc(1, 0, 32'h0, 1);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 32'hA0 + i, 1);
      chk("stream_data", bus.out_data, 32'hA0 + i);
      chk("stream_ready", {31'd0, bus.in_ready}, 32'd1);
    end
    cyc(0, 0, 32'h0, 1);
    cyc(0, 0, 32'h0, 1);
`ifdef SKID_BUF_STATS_EN
    chk("stream_in_count", bus.in_count, 32'd8);
    chk("stream_out_count", bus.out_count, 32'd8);
`endif

    // Skid on downstream stall, then drain.
    cyc(1, 0, 32'h0, 1);
    cyc(0, 1, 32'hB0, 1);
    cyc(0, 1, 32'hB1, 0);
    chk("skid_level", {30'd0, bus.level}, 32'd2);
    chk("skid_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("skid_head", bus.out_data, 32'hB0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 32'hB2, 0);
    chk("skid_hold", bus.out_data, 32'hB0);
`ifdef SKID_BUF_STATS_EN
    chk("skid_stall_count", bus.stall_count, 32'd4);
`endif
    cyc(0, 1, 32'hB2, 1);
    chk("recover_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("recover_data", bus.out_data, 32'hB1);
    cyc(0, 1, 32'hB2, 1);
    chk("drain_data", bus.out_data, 32'hB2);
    cyc(0, 0, 32'h0, 1);
    chk("drain_level", {30'd0, bus.level}, 32'd0);

    // Flush while full.
    cyc(1, 0, 32'h0, 1);
    cyc(0, 1, 32'hC0, 0);
    cyc(0, 1, 32'hC1, 0);
    chk("flush_full", {30'd0, bus.level}, 32'd2);
    cyc(1, 1, 32'hEE, 1);
    chk("flush_level", {30'd0, bus.level}, 32'd0);
    chk("flush_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_ready", {31'd0, bus.in_ready}, 32'd1);
    cyc(0, 1, 32'hD0, 1);
    chk("flush_next", bus.out_data, 32'hD0);
    cyc(0, 0, 32'h0, 1);

    // Randomized traffic; in_data is junk whenever in_valid is low.
    begin
      int beats = 0;
      int cycles = 0;
      logic [DW-1:0] val = 32'h1000;
      cyc(1, 0, 32'h0, 1);
      while (beats < 1000 && cycles < 20000) begin
        logic v, acc;
        v = $urandom_range(0, 1) == 1;
        rst           = 1'b0;
        bus.in_valid  = v;
        bus.in_data   = v ? val : $urandom;
        bus.out_ready = $urandom_range(0, 1) == 1;
        acc = v && bus.in_ready;
        @(posedge clk);
        #1;
        if (acc) begin
          val = val + 32'd1;
          beats++;
        end
        cycles++;
      end
      if (beats < 1000) begin
        total++;
        bad++;
        $display("FAIL random_budget: got %0d beats want 1000", beats);
      end
      for (int i = 0; i < 4; i++) cyc(0, 0, 32'h0, 1);
      chk("random_drained", sb.size(), 32'd0);
      chk("random_level", {30'd0, bus.level}, 32'd0);
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/skid_buffer.md
# skid_buffer

Two-entry valid/ready register slice that registers the backward (ready) path, complementing the existing forward pipeline register, which registers data/valid but passes `out_ready` combinationally to `in_ready`. Used in long handshake chains to break the ready timing path without losing throughput: `in_ready` is driven straight from a flop, and a skid entry absorbs the one beat already in flight when downstream stalls. It sits between any valid/ready producer and consumer in the datapath.

## Interface
- DATA_W, 32, payload width in bits
- clk  input  1  rising-edge clock, only clock
- rst  input  1  reset: synchronous, active-high (sampled on `clk` rising edge)
- in_valid  input  1  upstream beat valid
- in_data  input  DATA_W  upstream payload
- in_ready  output  1  slice can accept a beat; driven directly from a flop
- out_valid  output  1  downstream beat valid
- out_data  output  DATA_W  downstream payload (main entry)
- out_ready  input  1  downstream accepts beat
- level  output  2  occupancy 0/1/2
- in_count, out_count, stall_count  output  32 each  statistics, present only with SKID_BUF_STATS_EN

## Operation
- `in_fire` = `in_valid & in_ready`; `out_fire` = `out_valid & out_ready`.
- Storage: `main_q` (always drives `out_data`) and `skid_q`.
- States: EMPTY (level 0), BUSY (level 1, `main_q` valid), FULL (level 2, both valid).
- Outputs: `out_valid` = state != EMPTY; `in_ready` = state != FULL. Both come from state flops, and neither is a function of the current-cycle `out_ready` or `in_valid`.
- EMPTY: on `in_fire`, `main_q`<=`in_data` and go to BUSY.
- BUSY with `in_fire` and `out_fire`: `main_q`<=`in_data`, stay BUSY.
- BUSY with `in_fire` only: `skid_q`<=`in_data`, go to FULL.
- BUSY with `out_fire` only: go to EMPTY.
- FULL: `in_fire` is impossible because `in_ready`=0. On `out_fire`, `main_q`<=`skid_q` and go to BUSY.
- Ordering is strict FIFO. No beat is dropped or duplicated. Data is unchanged bit-for-bit.
- `out_data` holds stable while `out_valid & !out_ready`. In EMPTY, `out_data` holds its last value (don't-care).
- `in_data` is ignored unless `in_fire`.

## Timing
- Reset (rst high at a clock edge): state EMPTY, `out_valid`=0, `in_ready`=1, `level`=0, `main_q`/`skid_q`=0, counters=0.
- Reset dominates every other event in the same cycle; any `in_fire`/`out_fire` in that cycle is discarded.
- Reset mid-operation flushes both entries, and the held beats are lost by design.
- Latency: a beat accepted at edge N is visible on `out_valid`/`out_data` after edge N, i.e. 1 cycle.
- Throughput: 1 beat/cycle sustained while `out_ready`=1.
- Stall: when `out_ready` falls while BUSY, one more beat is accepted into skid. `in_ready` drops the cycle after.
- Recovery: `in_ready` rises the cycle after the first `out_fire` in FULL.
- `level` is registered and always consistent with state.

## Configuration
- SKID_BUF_STATS_EN defined: adds `in_count` (+1 per `in_fire`), `out_count` (+1 per `out_fire`) and `stall_count` (+1 per cycle with `out_valid & !out_ready`).
  - All three are 32-bit, wrap modulo 2^32, reset to 0, and update at the same edge as the event.
- SKID_BUF_STATS_EN undefined: the three ports and their counter logic are absent. Handshake behaviour is identical.

## Structure
- Package `skid_buf_pkg`: `skid_state_t` enum {EMPTY, BUSY, FULL}, default `DATA_W` constant, and `STAT_W` = 32.
- Sub-module `skid_buf_stat_cnt`: one wrapping counter with enable and synchronous reset. It is instantiated 3x, only under SKID_BUF_STATS_EN.

## Test plan
- Reset: hold rst=1 for 3 cycles with `in_valid`=1 and `in_data`=0x11 → `out_valid`=0, `in_ready`=1, `level`=0, nothing accepted. First beat after release is accepted normally.
- Streaming: `out_ready`=1, send 0xA0..0xA7 back-to-back → outputs 0xA0..0xA7 in order, each 1 cycle after its input, `in_ready` never drops. With stats: `in_count`=`out_count`=8.
- Skid: stream 0xB0, 0xB1, 0xB2 and drop `out_ready` after 0xB0 is presented → 0xB1 goes into skid, `level`=2, `in_ready`=0 the next cycle. 0xB0 is held on `out_data` throughout the stall.
- Drain: from the FULL state above, raise `out_ready` → 0xB0, 0xB1, 0xB2 delivered in order. `in_ready`=1 one cycle after the first `out_fire`. With stats: `stall_count` = number of stalled cycles.
- Randomized `in_valid`/`out_ready` at 50% each, 1000 beats of an incrementing pattern → scoreboard shows no loss, duplication or reorder. `out_data` is stable during stalls, and `in_ready` equals `level`!=2 every cycle.
- Mid-flush: reach FULL (0xC0, 0xC1), then pulse rst=1 for 1 cycle → `level`=0, `out_valid`=0, `in_ready`=1. The next input 0xD0 appears first on the output.
